// File: rtl/ip_packet_rx.sv
// ip_packet_rx: parses fixed 34-byte Ethernet/IPv4 frames from the MAC byte stream and hands
// accepted messages to the accelerator core; rejected frames are drained and counted.
// Ports:
//   ACLK, ARESET (async, active-low)
//   ACCELERATOR_IP_ADDRESS / ACCELERATOR_MAC_ADDRESS : local addresses, static out of reset
//   MAC_DATA_IN/VALID/FIRST/LAST in, MAC_DATA_READY out : inbound byte stream
//   SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, RECEIVED_MESSAGE, MESSAGE_VALID out,
//   MESSAGE_ACCEPT in : result handshake
//   DROP_COUNT out : saturating count of discarded frames
module ip_packet_rx #(
    parameter int AXI_S_DATA_WIDTH = 8,
    parameter int IP_ADDR_WIDTH    = 32,
    parameter int MAC_ADDR_WIDTH   = 48,
    parameter int ACCEL_DATA_WIDTH = 10
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    input  logic                        MAC_DATA_FIRST,
    input  logic                        MAC_DATA_LAST,
    output logic                        MAC_DATA_READY,
    output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
    output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
    output logic [ACCEL_DATA_WIDTH-1:0] RECEIVED_MESSAGE,
    output logic                        MESSAGE_VALID,
    input  logic                        MESSAGE_ACCEPT,
    output logic [15:0]                 DROP_COUNT
);
    typedef enum logic [2:0] {IDLE, RECV_ETH_HDR, RECV_IP_HDR, RECV_USER_DATA, HOLD_RESULT} state_t;
    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d, cur_idx, nxt_idx, mac_sh;
    logic [4:0]  ip_sh;
    logic        beat, start, abort, deliver, term_drop;
    logic        uc_q, uc_d, uc_n, bc_q, bc_d, bc_n, bad_q, bad_d, bad_n;
    logic [15:0] acc_q, acc_d, acc_b, acc_new, word;
    logic [16:0] sum17, drop_sum;
    logic [7:0]  b, hi_q, hi_d, mac_byte, ip_byte;
    logic [47:0] smac_q, smac_d, omac_q, omac_d;
    logic [31:0] sip_q, sip_d, oip_q, oip_d;
    logic [1:0]  mhi_q, mhi_d;
    logic [9:0]  omsg_q, omsg_d;
    logic [15:0] drop_q, drop_d;
    logic        ready_q, valid_q, valid_d;
    assign b         = MAC_DATA_IN;
    assign beat      = MAC_DATA_VALID & ready_q;
    // A beat in IDLE, or a FIRST beat mid-frame, starts a fresh frame at byte 0.
    assign start     = beat & ((state_q == IDLE) | MAC_DATA_FIRST);
    assign abort     = beat & MAC_DATA_FIRST & (state_q != IDLE);
    assign cur_idx   = start ? 6'd0 : idx_q;
    assign nxt_idx   = (cur_idx == 6'd63) ? 6'd63 : cur_idx + 6'd1;
    assign mac_sh    = 6'd40 - {cur_idx[2:0], 3'b000};
    assign mac_byte  = 8'(ACCELERATOR_MAC_ADDRESS >> mac_sh);
    assign ip_sh     = 5'd24 - {cur_idx[1:0], 3'b000};
    assign ip_byte   = 8'(ACCELERATOR_IP_ADDRESS >> ip_sh);
    // Header checksum: each odd byte completes a big-endian word with the previous byte.
    assign acc_b     = start ? 16'd0 : acc_q;
    assign word      = {hi_q, b};
    assign sum17     = {1'b0, acc_b} + {1'b0, word};
    assign acc_new   = sum17[15:0] + {15'd0, sum17[16]};
    // Destination MAC must match either the local address or broadcast; track both misses.
    assign uc_n      = (~start & uc_q) | (cur_idx < 6'd6 && b != mac_byte);
    assign bc_n      = (~start & bc_q) | (cur_idx < 6'd6 && b != 8'hFF);
    assign bad_n     = (~start & bad_q)
                     | (cur_idx == 6'd12 && b != 8'h45)
                     | (cur_idx == 6'd14 && b != 8'h00)
                     | (cur_idx == 6'd15 && b != 8'h16)
                     | (cur_idx >= 6'd28 && cur_idx <= 6'd31 && b != ip_byte)
                     | (cur_idx == 6'd31 && acc_new != 16'hFFFF);
    assign deliver   = beat & MAC_DATA_LAST & (cur_idx == 6'd33) & ~bad_n & ~(uc_n & bc_n);
    assign term_drop = beat & MAC_DATA_LAST & ~deliver;
    assign drop_sum  = {1'b0, drop_q} + {16'd0, abort} + {16'd0, term_drop};
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        uc_d    = uc_q;
        bc_d    = bc_q;
        bad_d   = bad_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        smac_d  = smac_q;
        sip_d   = sip_q;
        mhi_d   = mhi_q;
        valid_d = valid_q;
        oip_d   = oip_q;
        omac_d  = omac_q;
        omsg_d  = omsg_q;
        drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (beat) begin
            uc_d    = uc_n;
            bc_d    = bc_n;
            bad_d   = bad_n;
            hi_d    = b;
            acc_d   = (cur_idx >= 6'd13 && cur_idx <= 6'd31 && cur_idx[0]) ? acc_new : acc_b;
            smac_d  = (cur_idx >= 6'd6 && cur_idx <= 6'd11) ? {smac_q[39:0], b} : smac_q;
            sip_d   = (cur_idx >= 6'd24 && cur_idx <= 6'd27) ? {sip_q[23:0], b} : sip_q;
            mhi_d   = (cur_idx == 6'd32) ? b[1:0] : mhi_q;
            idx_d   = MAC_DATA_LAST ? 6'd0 : nxt_idx;
            state_d = MAC_DATA_LAST ? (deliver ? HOLD_RESULT : IDLE)
                    : nxt_idx < 6'd12 ? RECV_ETH_HDR
                    : nxt_idx < 6'd32 ? RECV_IP_HDR : RECV_USER_DATA;
        end
        if (deliver) begin
            valid_d = 1'b1;
            oip_d   = sip_q;
            omac_d  = smac_q;
            omsg_d  = {mhi_q, b};
        end
        if (state_q == HOLD_RESULT && MESSAGE_ACCEPT) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            uc_q    <= 1'b0;
            bc_q    <= 1'b0;
            bad_q   <= 1'b0;
            acc_q   <= '0;
            hi_q    <= '0;
            smac_q  <= '0;
            sip_q   <= '0;
            mhi_q   <= '0;
            valid_q <= 1'b0;
            oip_q   <= '0;
            omac_q  <= '0;
            omsg_q  <= '0;
            drop_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            uc_q    <= uc_d;
            bc_q    <= bc_d;
            bad_q   <= bad_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            smac_q  <= smac_d;
            sip_q   <= sip_d;
            mhi_q   <= mhi_d;
            valid_q <= valid_d;
            oip_q   <= oip_d;
            omac_q  <= omac_d;
            omsg_q  <= omsg_d;
            drop_q  <= drop_d;
            ready_q <= (state_d != HOLD_RESULT);
        end
    end
    assign MAC_DATA_READY     = ready_q;
    assign MESSAGE_VALID      = valid_q;
    assign SENDER_IP_ADDRESS  = oip_q;
    assign SENDER_MAC_ADDRESS = omac_q;
    assign RECEIVED_MESSAGE   = omsg_q;
    assign DROP_COUNT         = drop_q;
endmodule

// File: tb/tb_ip_packet_rx.sv
// tb_ip_packet_rx: directed self-checking bench for ip_packet_rx.
module tb_ip_packet_rx;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [31:0] ACCELERATOR_IP_ADDRESS = 32'h0A000002;
    logic [47:0] ACCELERATOR_MAC_ADDRESS = 48'h020000000001;
    logic [7:0]  MAC_DATA_IN = 8'h00;
    logic        MAC_DATA_VALID = 1'b0;
    logic        MAC_DATA_FIRST = 1'b0;
    logic        MAC_DATA_LAST = 1'b0;
    logic        MAC_DATA_READY;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [9:0]  RECEIVED_MESSAGE;
    logic        MESSAGE_VALID;
    logic        MESSAGE_ACCEPT = 1'b0;
    logic [15:0] DROP_COUNT;
    int checks = 0;
    int errors = 0;
    logic [7:0] fr [0:39];
    ip_packet_rx dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ACCELERATOR_IP_ADDRESS(ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS(ACCELERATOR_MAC_ADDRESS),
        .MAC_DATA_IN(MAC_DATA_IN), .MAC_DATA_VALID(MAC_DATA_VALID),
        .MAC_DATA_FIRST(MAC_DATA_FIRST), .MAC_DATA_LAST(MAC_DATA_LAST),
        .MAC_DATA_READY(MAC_DATA_READY),
        .SENDER_IP_ADDRESS(SENDER_IP_ADDRESS), .SENDER_MAC_ADDRESS(SENDER_MAC_ADDRESS),
        .RECEIVED_MESSAGE(RECEIVED_MESSAGE), .MESSAGE_VALID(MESSAGE_VALID),
        .MESSAGE_ACCEPT(MESSAGE_ACCEPT), .DROP_COUNT(DROP_COUNT)
    );
    always #5 ACLK = ~ACLK;
    task automatic build(input logic [47:0] dmac, input logic [47:0] smac, input logic [31:0] sip,
                         input logic [31:0] dip, input logic [9:0] msg);
        int sum;
        for (int k = 0; k < 40; k++) fr[k] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            fr[k]     = dmac[8*(5-k) +: 8];
            fr[6 + k] = smac[8*(5-k) +: 8];
        end
        fr[12] = 8'h45; fr[13] = 8'h00; fr[14] = 8'h00; fr[15] = 8'h16;
        fr[16] = 8'h12; fr[17] = 8'h34; fr[18] = 8'h40; fr[19] = 8'h00;
        fr[20] = 8'h40; fr[21] = 8'h11; fr[22] = 8'h00; fr[23] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            fr[24 + k] = sip[8*(3-k) +: 8];
            fr[28 + k] = dip[8*(3-k) +: 8];
        end
        fr[32] = {6'b101100, msg[9:8]};
        fr[33] = msg[7:0];
        sum = 0;
        for (int k = 0; k < 10; k++) sum += {16'd0, fr[12 + 2*k], fr[13 + 2*k]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >>> 16);
        fr[22] = ~sum[15:8];
        fr[23] = ~sum[7:0];
    endtask
    task automatic send_byte(input logic [7:0] v, input logic f, input logic l);
        int n = 0;
        MAC_DATA_IN = v; MAC_DATA_VALID = 1'b1; MAC_DATA_FIRST = f; MAC_DATA_LAST = l;
        while (!MAC_DATA_READY && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL ready_timeout: READY stayed %b, required 1", MAC_DATA_READY);
        end
        @(posedge ACLK); #1;
        MAC_DATA_VALID = 1'b0; MAC_DATA_FIRST = 1'b0; MAC_DATA_LAST = 1'b0;
    endtask
    task automatic send_range(input int lo, input int hi, input int last_at);
        for (int k = lo; k <= hi; k++) send_byte(fr[k], k == 0, k == last_at);
    endtask
    task automatic do_reset();
        MESSAGE_ACCEPT = 1'b0; MAC_DATA_VALID = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
    endtask
    task automatic check_result(input string tag, input logic [31:0] ip, input logic [47:0] mac,
                                input logic [9:0] msg, input logic [15:0] drops);
        checks++;
        if (MESSAGE_VALID !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", tag, MESSAGE_VALID); end
        checks++;
        if (SENDER_IP_ADDRESS !== ip) begin errors++; $display("FAIL %s ip: got %h want %h", tag, SENDER_IP_ADDRESS, ip); end
        checks++;
        if (SENDER_MAC_ADDRESS !== mac) begin errors++; $display("FAIL %s mac: got %h want %h", tag, SENDER_MAC_ADDRESS, mac); end
        checks++;
        if (RECEIVED_MESSAGE !== msg) begin errors++; $display("FAIL %s msg: got %h want %h", tag, RECEIVED_MESSAGE, msg); end
        checks++;
        if (DROP_COUNT !== drops) begin errors++; $display("FAIL %s drops: got %0d want %0d", tag, DROP_COUNT, drops); end
        checks++;
        if (MAC_DATA_READY !== 1'b0) begin errors++; $display("FAIL %s hold_ready: got %b want 0", tag, MAC_DATA_READY); end
    endtask
    task automatic accept(input string tag);
        MESSAGE_ACCEPT = 1'b1;
        @(posedge ACLK); #1;
        MESSAGE_ACCEPT = 1'b0;
        checks++;
        if (MESSAGE_VALID !== 1'b0 || MAC_DATA_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: valid %b ready %b, want valid 0 ready 1", tag, MESSAGE_VALID, MAC_DATA_READY);
        end
    endtask
    task automatic check_drop(input string tag, input logic [15:0] drops);
        checks++;
        if (MESSAGE_VALID !== 1'b0 || DROP_COUNT !== drops || MAC_DATA_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s drop: valid %b drops %0d ready %b, want valid 0 drops %0d ready 1",
                     tag, MESSAGE_VALID, DROP_COUNT, MAC_DATA_READY, drops);
        end
    endtask
    task automatic test_reset();
        #2;
        checks++;
        if (MAC_DATA_READY !== 1'b0 || MESSAGE_VALID !== 1'b0 || DROP_COUNT !== 16'd0 ||
            SENDER_IP_ADDRESS !== 32'd0 || SENDER_MAC_ADDRESS !== 48'd0 || RECEIVED_MESSAGE !== 10'd0) begin
            errors++;
            $display("FAIL reset_values: ready %b valid %b drops %h ip %h mac %h msg %h, want all 0",
                     MAC_DATA_READY, MESSAGE_VALID, DROP_COUNT, SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, RECEIVED_MESSAGE);
        end
        do_reset();
        checks++;
        if (MAC_DATA_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", MAC_DATA_READY); end
    endtask
    task automatic test_valid_unicast();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000002, 10'h2A5);
        send_range(0, 33, 33);
        check_result("unicast", 32'h0A000009, 48'h020000000009, 10'h2A5, 16'd0);
        accept("unicast");
    endtask
    task automatic test_bad_checksum();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000002, 10'h2A5);
        fr[22] = fr[22] ^ 8'h01;
        send_range(0, 33, 33);
        check_drop("bad_checksum", 16'd1);
    endtask
    task automatic test_wrong_ip_then_bcast();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000003, 10'h2A5);
        send_range(0, 33, 33);
        check_drop("wrong_ip", 16'd1);
        build(48'hFFFFFFFFFFFF, 48'h02000000000B, 32'h0A00000B, 32'h0A000002, 10'h0F0);
        send_range(0, 33, 33);
        check_result("bcast", 32'h0A00000B, 48'h02000000000B, 10'h0F0, 16'd1);
        accept("bcast");
    endtask
    task automatic test_truncate_abort();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000002, 10'h2A5);
        send_range(0, 20, 20);
        check_drop("truncated", 16'd1);
        send_range(0, 9, -1);
        build(48'h020000000001, 48'h020000000077, 32'h0A000011, 32'h0A000002, 10'h155);
        send_byte(fr[0], 1'b1, 1'b0);
        checks++;
        if (DROP_COUNT !== 16'd2) begin errors++; $display("FAIL abort_count: got %0d want 2", DROP_COUNT); end
        send_range(1, 33, 33);
        check_result("restarted", 32'h0A000011, 48'h020000000077, 10'h155, 16'd2);
        accept("restarted");
        send_range(0, 35, 35);
        check_drop("overlong", 16'd3);
    endtask
    task automatic test_back_to_back_hold();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000002, 10'h2A5);
        send_range(0, 33, 33);
        build(48'h020000000001, 48'h020000000033, 32'h0A000033, 32'h0A000002, 10'h3C3);
        MAC_DATA_IN = fr[0]; MAC_DATA_VALID = 1'b1; MAC_DATA_FIRST = 1'b1; MAC_DATA_LAST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_result("hold", 32'h0A000009, 48'h020000000009, 10'h2A5, 16'd0);
            @(posedge ACLK); #1;
        end
        accept("hold");
        @(posedge ACLK); #1;
        MAC_DATA_VALID = 1'b0; MAC_DATA_FIRST = 1'b0;
        send_range(1, 33, 33);
        check_result("after_hold", 32'h0A000033, 48'h020000000033, 10'h3C3, 16'd0);
        accept("after_hold");
    endtask
    task automatic test_reset_midframe();
        do_reset();
        build(48'h020000000001, 48'h020000000009, 32'h0A000009, 32'h0A000002, 10'h2A5);
        send_range(0, 33, 33);
        accept("pre_reset");
        send_range(0, 24, -1);
        MAC_DATA_IN = fr[25]; MAC_DATA_VALID = 1'b1;
        #2 ARESET = 1'b0;
        #1;
        checks++;
        if (MAC_DATA_READY !== 1'b0 || MESSAGE_VALID !== 1'b0 || SENDER_IP_ADDRESS !== 32'd0 ||
            SENDER_MAC_ADDRESS !== 48'd0 || RECEIVED_MESSAGE !== 10'd0 || DROP_COUNT !== 16'd0) begin
            errors++;
            $display("FAIL midframe_reset: ready %b valid %b ip %h mac %h msg %h drops %h, want all 0",
                     MAC_DATA_READY, MESSAGE_VALID, SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, RECEIVED_MESSAGE, DROP_COUNT);
        end
        MAC_DATA_VALID = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        build(48'h020000000001, 48'h020000000044, 32'h0A000044, 32'h0A000002, 10'h001);
        send_range(0, 33, 33);
        check_result("post_reset", 32'h0A000044, 48'h020000000044, 10'h001, 16'd0);
        accept("post_reset");
    endtask
    initial begin
        test_reset();
        test_valid_unicast();
        test_bad_checksum();
        test_wrong_ip_then_bcast();
        test_truncate_abort();
        test_back_to_back_hold();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ip_packet_rx.md
# ip_packet_rx

Receive-side counterpart of the accelerator's IPv4 transmit packager. Consumes the 8-bit byte stream from the MAC and parses the fixed 34-byte frame format the accelerator emits: 12-byte Ethernet address header, 20-byte IPv4 header and a 2-byte payload. Frames addressed to the accelerator that pass all checks are presented to the accelerator core as a sender address pair plus a 10-bit message, using a valid/accept handshake. All other frames are drained and counted.

## Interface
- AXI_S_DATA_WIDTH, 8, MAC byte-stream width (fixed).
- IP_ADDR_WIDTH, 32, IPv4 address width.
- MAC_ADDR_WIDTH, 48, MAC address width.
- ACCEL_DATA_WIDTH, 10, payload message width.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-low reset.
- ACCELERATOR_IP_ADDRESS  in  32  local IP; static while out of reset.
- ACCELERATOR_MAC_ADDRESS  in  48  local MAC; static while out of reset.
- MAC_DATA_IN  in  8  received byte.
- MAC_DATA_VALID  in  1  byte valid.
- MAC_DATA_FIRST  in  1  marks byte 0 of a frame.
- MAC_DATA_LAST  in  1  marks final byte of a frame.
- MAC_DATA_READY  out  1  block can accept a byte.
- SENDER_IP_ADDRESS  out  32  source IP of the accepted frame (header bytes 12-15).
- SENDER_MAC_ADDRESS  out  48  source MAC of the accepted frame (frame bytes 6-11).
- RECEIVED_MESSAGE  out  10  payload {byte32[1:0], byte33}.
- MESSAGE_VALID  out  1  result outputs are valid.
- MESSAGE_ACCEPT  in  1  core consumes the result.
- DROP_COUNT  out  16  saturating count of discarded frames.

## Operation
- A byte transfers only in a cycle where MAC_DATA_VALID=1 and MAC_DATA_READY=1 (a "beat"). A 6-bit byte index counts beats within the frame.
- The state machine has five states: IDLE, RECV_ETH_HDR, RECV_IP_HDR, RECV_USER_DATA and HOLD_RESULT.
  - IDLE: waits for a beat. Any beat in IDLE is treated as byte 0, whether or not FIRST is set, and moves to RECV_ETH_HDR.
  - RECV_ETH_HDR covers bytes 0-11. Bytes 0-5 are the destination MAC and bytes 6-11 the source MAC, captured into shadow registers.
  - RECV_IP_HDR covers bytes 12-31.
  - RECV_USER_DATA covers bytes 32-33.
  - HOLD_RESULT: MESSAGE_VALID=1 and MAC_DATA_READY=0. It returns to IDLE in the cycle MESSAGE_ACCEPT=1.
- Checks run on the fly. Each failure sets a sticky bad flag for the current frame:
  - Destination MAC must equal ACCELERATOR_MAC_ADDRESS, or be FF:FF:FF:FF:FF:FF.
  - Byte 12 must be 0x45.
  - Bytes 14-15 (total length) must be 0x0016.
  - Bytes 28-31 (destination IP) must equal ACCELERATOR_IP_ADDRESS.
  - The header checksum must be valid. Bytes 12-31 are taken as ten big-endian 16-bit words and summed into a 17-bit accumulator with end-around carry folded on every add. The header is valid iff the final folded sum equals 0xFFFF.
  - TTL, protocol, identification and flags are not checked. The upper 6 bits of byte 32 are ignored.
- Frame end:
  - A beat with LAST=1 at byte index 33 and no bad flag moves the shadow fields into the output registers and enters HOLD_RESULT.
  - Any other outcome returns to IDLE and increments DROP_COUNT. This covers LAST at index 33 with the bad flag set, LAST before index 33 (truncated), and index 33 without LAST. For the index-33-without-LAST case, the block first drains beats until LAST, then increments.
- A beat with FIRST=1 while not in IDLE or HOLD_RESULT aborts the current frame and increments DROP_COUNT. That byte then restarts parsing as byte 0 (same cycle, no beat lost).
- DROP_COUNT saturates at 0xFFFF.

## Timing
- Reset values: MAC_DATA_READY=0 while ARESET=0. SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, RECEIVED_MESSAGE, MESSAGE_VALID and DROP_COUNT are all 0. State is IDLE and the byte index is 0.
- MAC_DATA_READY=1 in every state except HOLD_RESULT, starting from the first cycle after ARESET deasserts.
- Latency: MESSAGE_VALID rises on the clock edge that captures the byte-33 beat. It is registered and visible the following cycle.
- MESSAGE_VALID and all result outputs stay stable until MESSAGE_ACCEPT is sampled high. MESSAGE_VALID falls on the next edge and MAC_DATA_READY returns to 1 in that same cycle.
- Back-to-back frames: byte 0 of the next frame can transfer in the cycle after the accept edge. A dropped frame's successor can start in the cycle after its LAST beat, or in the same cycle via FIRST.
- DROP_COUNT updates on the edge of the terminating beat.
- ARESET asserted mid-frame or in HOLD_RESULT discards all partial state and returns every output to its reset value immediately.

## Test plan
- Valid unicast frame: dst MAC 02:00:00:00:00:01, dst IP 10.0.0.2, src IP 10.0.0.9, src MAC 02:00:00:00:00:09, message 0x2A5, checksum correct, valid every cycle → MESSAGE_VALID one cycle after byte 33. Outputs are SENDER_IP_ADDRESS=0x0A000009, SENDER_MAC_ADDRESS=0x020000000009, RECEIVED_MESSAGE=0x2A5, DROP_COUNT=0.
- Same frame with byte 22 (checksum high byte) XOR 0x01 → no MESSAGE_VALID, DROP_COUNT=1, READY stays 1.
- Wrong dst IP (10.0.0.3) frame, then broadcast-MAC valid frame → first dropped (DROP_COUNT=1), second delivered.
- Truncated frame with LAST on byte 20, then FIRST asserted mid-frame at byte 10 of another → DROP_COUNT=2; restarted frame delivered correctly.
- Valid frame with MESSAGE_ACCEPT held low 5 cycles and MAC_DATA_VALID held high → READY=0 for those cycles, outputs stable, no bytes consumed. Accept → next frame byte 0 taken the following cycle.
- ARESET pulsed low at byte 25 of a valid frame → outputs zero; a clean frame after reset delivered; DROP_COUNT=0.
